// File: rtl/trap_pkg.sv
// Constants, state encodings and CSR-update helpers shared by the trap/debug-entry controller.
// Optional NMI support in trap_ctrl is enabled by defining TRAP_CTRL_NMI_EN.
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_DCSR    = 12'h7B0;
   localparam logic [11:0] CSR_DPC     = 12'h7B1;

   localparam logic [4:0] CAUSE_ILLEGAL   = 5'd2;
   localparam logic [4:0] CAUSE_EBREAK    = 5'd3;
   localparam logic [4:0] CAUSE_ECALL     = 5'd11;
   localparam logic [4:0] CAUSE_IRQ_SW    = 5'd3;
   localparam logic [4:0] CAUSE_IRQ_TIMER = 5'd7;
   localparam logic [4:0] CAUSE_IRQ_EXT   = 5'd11;
   localparam logic [4:0] CAUSE_FAST_BASE = 5'd16;
   localparam logic [4:0] CAUSE_NMI       = 5'd31;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam int MIE_MSIE      = 3;
   localparam int MIE_MTIE      = 7;
   localparam int MIE_MEIE      = 11;
   localparam int MIE_FAST_BASE = 16;

   localparam int DCSR_EBREAKM  = 15;

   typedef enum logic [2:0] {
      DBG_CAUSE_NONE      = 3'd0,
      DBG_CAUSE_EBREAK_DM = 3'd1,
      DBG_CAUSE_HALTREQ   = 3'd3,
      DBG_CAUSE_EBREAKM   = 3'd4
   } dbg_cause_t;

   typedef enum logic [4:0] {
      S_IDLE      = 5'b00001,
      S_W_MEPC    = 5'b00010,
      S_W_MSTATUS = 5'b00100,
      S_W_DCSR    = 5'b01000,
      S_ASSERT    = 5'b10000
   } state_t;

   // Vectored offset applies to interrupts only; reserved modes 2/3 behave as direct.
   function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                               input logic        irq,
                                               input logic [4:0]  code);
      logic [31:0] base;
      base = {mtvec[31:2], 2'b00};
      if (irq && (mtvec[1:0] == 2'b01))
         return base + {25'd0, code, 2'b00};
      return base;
   endfunction

   function automatic logic [31:0] mstatus_on_trap(input logic [31:0] mstatus);
      logic [31:0] v;
      v = mstatus;
      v[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
      v[MSTATUS_MIE]  = 1'b0;
      v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return v;
   endfunction

   function automatic logic [31:0] mstatus_on_mret(input logic [31:0] mstatus);
      logic [31:0] v;
      v = mstatus;
      v[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
      v[MSTATUS_MPIE] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/trap_irq_arb.sv
// Combinational interrupt priority encoder: lowest fast line, then external, software, timer.
// Every source is gated by its mie enable bit.
module trap_irq_arb
   import trap_pkg::*;
#(
   parameter int NUM_FAST_IRQ = 15
) (
   input  logic [31:0]             mie,
   input  logic                    irq_software,
   input  logic                    irq_timer,
   input  logic                    irq_external,
   input  logic [NUM_FAST_IRQ-1:0] irq_fast,
   output logic                    req,
   output logic                    irq,
   output logic [4:0]              code
);

   logic [NUM_FAST_IRQ-1:0] fast_pend;
   logic                    unused_mie;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FAST_IRQ; gi++) begin : g_fast
         assign fast_pend[gi] = irq_fast[gi] & mie[MIE_FAST_BASE + gi];
      end
   endgenerate

   // Lowest-priority source is evaluated first so later matches override it.
   always_comb begin
      req  = 1'b0;
      code = 5'd0;
      if (irq_timer & mie[MIE_MTIE]) begin
         req  = 1'b1;
         code = CAUSE_IRQ_TIMER;
      end
      if (irq_software & mie[MIE_MSIE]) begin
         req  = 1'b1;
         code = CAUSE_IRQ_SW;
      end
      if (irq_external & mie[MIE_MEIE]) begin
         req  = 1'b1;
         code = CAUSE_IRQ_EXT;
      end
      for (int i = NUM_FAST_IRQ - 1; i >= 0; i--) begin
         if (fast_pend[i]) begin
            req  = 1'b1;
            code = CAUSE_FAST_BASE + 5'(i);
         end
      end
   end

   assign irq        = req;
   assign unused_mie = ^mie;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap and debug-entry controller: arbitrates, sequences CSR writes, then redirects.
// Define TRAP_CTRL_NMI_EN to add the irq_nmi_i input and NMI_ADDR parameter.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int NUM_FAST_IRQ = 15,
   parameter int DEBUG_EN     = 1
`ifdef TRAP_CTRL_NMI_EN
   ,
   parameter logic [31:0] NMI_ADDR = 32'h0000_0100
`endif
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    inst_valid_i,
   input  logic                    inst_ecall_i,
   input  logic                    inst_ebreak_i,
   input  logic                    inst_illegal_i,
   input  logic                    inst_mret_i,
   input  logic                    inst_dret_i,
   input  logic [31:0]             inst_addr_i,
   input  logic [31:0]             mtvec_i,
   input  logic [31:0]             mepc_i,
   input  logic [31:0]             mstatus_i,
   input  logic [31:0]             mie_i,
   input  logic [31:0]             dpc_i,
   input  logic [31:0]             dcsr_i,
   input  logic                    irq_software_i,
   input  logic                    irq_timer_i,
   input  logic                    irq_external_i,
   input  logic [NUM_FAST_IRQ-1:0] irq_fast_i,
`ifdef TRAP_CTRL_NMI_EN
   input  logic                    irq_nmi_i,
`endif
   input  logic [31:0]             debug_halt_addr_i,
   input  logic                    debug_req_i,
   output logic                    csr_we_o,
   output logic [31:0]             csr_waddr_o,
   output logic [31:0]             csr_wdata_o,
   output logic                    stall_flag_o,
   output logic [31:0]             int_addr_o,
   output logic                    int_assert_o,
   output logic                    debug_mode_o
);

   localparam logic DBG_EN = (DEBUG_EN != 0);

   state_t      state_reg, state_next;
   logic        debug_mode_reg, debug_mode_next;
   logic [31:0] target_reg, target_next;
   logic [31:0] pc_reg, pc_next;
   dbg_cause_t  dcause_reg, dcause_next;

   logic        arb_req, arb_irq;
   logic [4:0]  arb_code;
   logic        valid, ebreakm;
   logic        int_take, exc_illegal, exc_ecall, exc_ebreak;
   logic        dbg_ebreak_dm, dbg_halt, dbg_ebreakm, mret_take, dret_take;
   logic        nmi_take;
   logic        trap_go, trap_irq;
   logic [4:0]  trap_code;

   trap_irq_arb #(
      .NUM_FAST_IRQ (NUM_FAST_IRQ)
   ) u_irq_arb (
      .mie          (mie_i),
      .irq_software (irq_software_i),
      .irq_timer    (irq_timer_i),
      .irq_external (irq_external_i),
      .irq_fast     (irq_fast_i),
      .req          (arb_req),
      .irq          (arb_irq),
      .code         (arb_code)
   );

   // Gating with rst_n keeps every output at 0 while reset is held.
   assign valid         = rst_n & inst_valid_i;
   assign ebreakm       = DBG_EN & dcsr_i[DCSR_EBREAKM];
   assign int_take      = valid & mstatus_i[MSTATUS_MIE] & ~debug_mode_reg & arb_req;
   assign exc_illegal   = valid & inst_illegal_i;
   assign exc_ecall     = valid & inst_ecall_i;
   assign exc_ebreak    = valid & inst_ebreak_i & ~ebreakm & ~debug_mode_reg;
   assign dbg_ebreak_dm = DBG_EN & valid & inst_ebreak_i & debug_mode_reg;
   assign dbg_halt      = DBG_EN & valid & debug_req_i & ~debug_mode_reg;
   assign dbg_ebreakm   = valid & inst_ebreak_i & ebreakm & ~debug_mode_reg;
   assign mret_take     = valid & inst_mret_i;
   assign dret_take     = DBG_EN & valid & inst_dret_i;

`ifdef TRAP_CTRL_NMI_EN
   localparam logic [31:0] NMI_TARGET = NMI_ADDR;
   logic nmi_q_reg, nmi_pending_reg, nmi_pending_next;

   // Edge capture keeps a short NMI pulse pending until the controller can take it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nmi_q_reg       <= 1'b0;
         nmi_pending_reg <= 1'b0;
      end else begin
         nmi_q_reg       <= irq_nmi_i;
         nmi_pending_reg <= nmi_pending_next;
      end
   end

   assign nmi_take         = valid & nmi_pending_reg & ~debug_mode_reg & (state_reg == S_IDLE);
   assign nmi_pending_next = (nmi_pending_reg & ~nmi_take) | (irq_nmi_i & ~nmi_q_reg);
`else
   localparam logic [31:0] NMI_TARGET = 32'd0;
   assign nmi_take = 1'b0;
`endif

   always_comb begin
      trap_go   = 1'b1;
      trap_irq  = 1'b0;
      trap_code = 5'd0;
      if (nmi_take) begin
         trap_irq  = 1'b1;
         trap_code = CAUSE_NMI;
      end else if (exc_illegal) begin
         trap_code = CAUSE_ILLEGAL;
      end else if (exc_ecall) begin
         trap_code = CAUSE_ECALL;
      end else if (exc_ebreak) begin
         trap_code = CAUSE_EBREAK;
      end else if (int_take) begin
         trap_irq  = arb_irq;
         trap_code = arb_code;
      end else begin
         trap_go = 1'b0;
      end
   end

   always_comb begin
      state_next      = state_reg;
      debug_mode_next = debug_mode_reg;
      target_next     = target_reg;
      pc_next         = pc_reg;
      dcause_next     = dcause_reg;
      csr_we_o        = 1'b0;
      csr_waddr_o     = 32'd0;
      csr_wdata_o     = 32'd0;
      stall_flag_o    = 1'b0;
      int_assert_o    = 1'b0;
      int_addr_o      = 32'd0;

      unique case (state_reg)
         S_IDLE: begin
            if (trap_go) begin
               stall_flag_o = 1'b1;
               csr_we_o     = 1'b1;
               csr_waddr_o  = {20'd0, CSR_MCAUSE};
               csr_wdata_o  = {trap_irq, 26'd0, trap_code};
               target_next  = nmi_take ? NMI_TARGET : trap_target(mtvec_i, trap_irq, trap_code);
               pc_next      = inst_addr_i;
               state_next   = S_W_MEPC;
            end else if (dbg_ebreak_dm | dbg_halt | dbg_ebreakm) begin
               stall_flag_o    = 1'b1;
               debug_mode_next = 1'b1;
               target_next     = debug_halt_addr_i;
               state_next      = S_W_DCSR;
               if (dbg_ebreak_dm) begin
                  dcause_next = DBG_CAUSE_EBREAK_DM;
               end else begin
                  dcause_next = dbg_halt ? DBG_CAUSE_HALTREQ : DBG_CAUSE_EBREAKM;
                  csr_we_o    = 1'b1;
                  csr_waddr_o = {20'd0, CSR_DPC};
                  csr_wdata_o = inst_addr_i;
               end
            end else if (mret_take) begin
               stall_flag_o = 1'b1;
               csr_we_o     = 1'b1;
               csr_waddr_o  = {20'd0, CSR_MSTATUS};
               csr_wdata_o  = mstatus_on_mret(mstatus_i);
               target_next  = mepc_i;
               state_next   = S_ASSERT;
            end else if (dret_take) begin
               stall_flag_o    = 1'b1;
               debug_mode_next = 1'b0;
               target_next     = dpc_i;
               state_next      = S_ASSERT;
            end
         end
         S_W_MEPC: begin
            stall_flag_o = 1'b1;
            csr_we_o     = 1'b1;
            csr_waddr_o  = {20'd0, CSR_MEPC};
            csr_wdata_o  = pc_reg;
            state_next   = S_W_MSTATUS;
         end
         S_W_MSTATUS: begin
            stall_flag_o = 1'b1;
            csr_we_o     = 1'b1;
            csr_waddr_o  = {20'd0, CSR_MSTATUS};
            csr_wdata_o  = mstatus_on_trap(mstatus_i);
            state_next   = S_ASSERT;
         end
         S_W_DCSR: begin
            stall_flag_o = 1'b1;
            csr_we_o     = 1'b1;
            csr_waddr_o  = {20'd0, CSR_DCSR};
            csr_wdata_o  = {dcsr_i[31:9], dcause_reg, dcsr_i[5:0]};
            state_next   = S_ASSERT;
         end
         S_ASSERT: begin
            int_assert_o = 1'b1;
            int_addr_o   = target_reg;
            state_next   = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         debug_mode_reg <= 1'b0;
         target_reg     <= 32'd0;
         pc_reg         <= 32'd0;
         dcause_reg     <= DBG_CAUSE_NONE;
      end else begin
         state_reg      <= state_next;
         debug_mode_reg <= debug_mode_next;
         target_reg     <= target_next;
         pc_reg         <= pc_next;
         dcause_reg     <= dcause_next;
      end
   end

   assign debug_mode_o = debug_mode_reg;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected CSR writes and redirects are queued as stimulus is
// driven and popped by a negedge monitor; scenario tasks check stall, latency and debug mode.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inst_valid_i, inst_ecall_i, inst_ebreak_i, inst_illegal_i, inst_mret_i, inst_dret_i;
   logic [31:0] inst_addr_i, mtvec_i, mepc_i, mstatus_i, mie_i, dpc_i, dcsr_i;
   logic        irq_software_i, irq_timer_i, irq_external_i;
   logic [14:0] irq_fast_i;
   logic [31:0] debug_halt_addr_i;
   logic        debug_req_i;
   logic        csr_we_o;
   logic [31:0] csr_waddr_o, csr_wdata_o, int_addr_o;
   logic        stall_flag_o, int_assert_o, debug_mode_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          redirect;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   trap_ctrl #(.NUM_FAST_IRQ(15), .DEBUG_EN(1)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .inst_valid_i      (inst_valid_i),
      .inst_ecall_i      (inst_ecall_i),
      .inst_ebreak_i     (inst_ebreak_i),
      .inst_illegal_i    (inst_illegal_i),
      .inst_mret_i       (inst_mret_i),
      .inst_dret_i       (inst_dret_i),
      .inst_addr_i       (inst_addr_i),
      .mtvec_i           (mtvec_i),
      .mepc_i            (mepc_i),
      .mstatus_i         (mstatus_i),
      .mie_i             (mie_i),
      .dpc_i             (dpc_i),
      .dcsr_i            (dcsr_i),
      .irq_software_i    (irq_software_i),
      .irq_timer_i       (irq_timer_i),
      .irq_external_i    (irq_external_i),
      .irq_fast_i        (irq_fast_i),
`ifdef TRAP_CTRL_NMI_EN
      .irq_nmi_i         (1'b0),
`endif
      .debug_halt_addr_i (debug_halt_addr_i),
      .debug_req_i       (debug_req_i),
      .csr_we_o          (csr_we_o),
      .csr_waddr_o       (csr_waddr_o),
      .csr_wdata_o       (csr_wdata_o),
      .stall_flag_o      (stall_flag_o),
      .int_addr_o        (int_addr_o),
      .int_assert_o      (int_assert_o),
      .debug_mode_o      (debug_mode_o)
   );

   always #5 clk = ~clk;

   // Monitor: every CSR write and every redirect must match the head of the scoreboard.
   always @(negedge clk) begin
      if (csr_we_o === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL csr_write: unexpected addr=%h data=%h, required no write", csr_waddr_o, csr_wdata_o);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.redirect || csr_waddr_o !== mon_e.addr || csr_wdata_o !== mon_e.data) begin
               errors++;
               $display("FAIL csr_write: got addr=%h data=%h, required redirect=%0b addr=%h data=%h",
                        csr_waddr_o, csr_wdata_o, mon_e.redirect, mon_e.addr, mon_e.data);
            end else
               $display("csr write  addr=%h data=%h", csr_waddr_o, csr_wdata_o);
         end
      end
      if (int_assert_o === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL redirect: unexpected target=%h, required no redirect", int_addr_o);
         end else begin
            mon_e = exp_q.pop_front();
            if (!mon_e.redirect || int_addr_o !== mon_e.addr) begin
               errors++;
               $display("FAIL redirect: got target=%h, required redirect=%0b addr=%h",
                        int_addr_o, mon_e.redirect, mon_e.addr);
            end else
               $display("redirect   target=%h", int_addr_o);
         end
      end
   end

   task automatic push_csr(input logic [31:0] addr, input logic [31:0] data);
      exp_t e;
      e.redirect = 1'b0;
      e.addr     = addr;
      e.data     = data;
      exp_q.push_back(e);
   endtask

   task automatic push_redirect(input logic [31:0] addr);
      exp_t e;
      e.redirect = 1'b1;
      e.addr     = addr;
      e.data     = 32'd0;
      exp_q.push_back(e);
   endtask

   task automatic drop_requests();
      inst_ecall_i   = 1'b0;
      inst_ebreak_i  = 1'b0;
      inst_illegal_i = 1'b0;
      inst_mret_i    = 1'b0;
      inst_dret_i    = 1'b0;
      irq_software_i = 1'b0;
      irq_timer_i    = 1'b0;
      irq_external_i = 1'b0;
      irq_fast_i     = '0;
      debug_req_i    = 1'b0;
   endtask

   // Counts posedges from the accepting edge until the redirect strobe; -1 if it never comes.
   task automatic wait_redirect(output int n);
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) drop_requests();
         if (int_assert_o === 1'b1) begin
            n = i;
            return;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({csr_we_o, csr_waddr_o, csr_wdata_o, stall_flag_o, int_addr_o, int_assert_o, debug_mode_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got we=%b waddr=%h wdata=%h stall=%b addr=%h assert=%b dbg=%b, required all 0",
                  csr_we_o, csr_waddr_o, csr_wdata_o, stall_flag_o, int_addr_o, int_assert_o, debug_mode_o);
      end
      rst_n = 1'b1;
      $display("reset released");
   endtask

   task automatic test_direct_trap();
      int n;
      @(posedge clk); #1;
      mtvec_i = 32'h8000_0000; mstatus_i = 32'h8; mie_i = 32'h800; inst_addr_i = 32'h1234;
      irq_external_i = 1'b1;
      push_csr(32'h342, 32'h8000_000B);
      push_csr(32'h341, 32'h0000_1234);
      push_csr(32'h300, 32'h0000_1880);
      push_redirect(32'h8000_0000);
      #1;
      checks++;
      if (stall_flag_o !== 1'b1) begin
         errors++;
         $display("FAIL direct_stall: got %b, required 1", stall_flag_o);
      end
      wait_redirect(n);
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL direct_latency: got %0d edges, required 3", n);
      end
      @(posedge clk); #1;
      checks++;
      if (int_assert_o !== 1'b0 || stall_flag_o !== 1'b0) begin
         errors++;
         $display("FAIL direct_one_cycle: got assert=%b stall=%b, required 0 0", int_assert_o, stall_flag_o);
      end
      $display("direct trap done, latency %0d", n);
   endtask

   typedef struct {
      logic [31:0] mtvec;
      logic [14:0] fast;
      logic [31:0] mie;
      logic        ext;
      logic [31:0] cause;
      logic [31:0] target;
   } vec_t;

   task automatic test_vectored();
      vec_t tbl[3];
      int   n;
      tbl[0] = '{32'h8000_0001, 15'h0024, 32'h0024_0800, 1'b1, 32'h8000_0012, 32'h8000_0048};
      tbl[1] = '{32'h8000_0103, 15'h0001, 32'h0001_0000, 1'b0, 32'h8000_0010, 32'h8000_0100};
      tbl[2] = '{32'hFFFF_FFC1, 15'h4000, 32'h4000_0000, 1'b0, 32'h8000_001E, 32'h0000_0038};
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         mtvec_i = tbl[k].mtvec; mie_i = tbl[k].mie; mstatus_i = 32'h8; inst_addr_i = 32'h500 + 32'(k);
         irq_fast_i = tbl[k].fast; irq_external_i = tbl[k].ext;
         push_csr(32'h342, tbl[k].cause);
         push_csr(32'h341, 32'h500 + 32'(k));
         push_csr(32'h300, 32'h0000_1880);
         push_redirect(tbl[k].target);
         wait_redirect(n);
         checks++;
         if (n !== 3) begin
            errors++;
            $display("FAIL vectored_latency[%0d]: got %0d edges, required 3", k, n);
         end
      end
   endtask

   task automatic test_exc_priority();
      logic [2:0] req_tbl[4];
      logic [31:0] cause_tbl[4];
      int n;
      // {illegal, ecall, ebreak}; the last row adds a timer IRQ that must lose to ecall.
      req_tbl[0] = 3'b111; cause_tbl[0] = 32'd2;
      req_tbl[1] = 3'b011; cause_tbl[1] = 32'd11;
      req_tbl[2] = 3'b001; cause_tbl[2] = 32'd3;
      req_tbl[3] = 3'b010; cause_tbl[3] = 32'd11;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         mtvec_i = 32'h8000_0001; mstatus_i = 32'h8; dcsr_i = 32'h0; inst_addr_i = 32'h300;
         mie_i = (k == 3) ? 32'h80 : 32'h0;
         irq_timer_i = (k == 3);
         {inst_illegal_i, inst_ecall_i, inst_ebreak_i} = req_tbl[k];
         push_csr(32'h342, cause_tbl[k]);
         push_csr(32'h341, 32'h300);
         push_csr(32'h300, 32'h0000_1880);
         push_redirect(32'h8000_0000);
         wait_redirect(n);
         checks++;
         if (n !== 3) begin
            errors++;
            $display("FAIL exc_latency[%0d]: got %0d edges, required 3", k, n);
         end
      end
   endtask

   task automatic test_mret();
      int n;
      @(posedge clk); #1;
      mstatus_i = 32'h1880; mepc_i = 32'h2000; mie_i = 32'h0;
      inst_mret_i = 1'b1;
      push_csr(32'h300, 32'h0000_1888);
      push_redirect(32'h0000_2000);
      wait_redirect(n);
      checks++;
      if (n !== 1) begin
         errors++;
         $display("FAIL mret_latency: got %0d edges, required 1", n);
      end
   endtask

   task automatic test_debug();
      int n;
      @(posedge clk); #1;
      mie_i = 32'h0; mstatus_i = 32'h0; dcsr_i = 32'h4000_0003; inst_addr_i = 32'h40;
      debug_halt_addr_i = 32'h0000_0800;
      debug_req_i = 1'b1;
      push_csr(32'h7B1, 32'h0000_0040);
      push_csr(32'h7B0, 32'h4000_00C3);
      push_redirect(32'h0000_0800);
      wait_redirect(n);
      checks++;
      if (n !== 2 || debug_mode_o !== 1'b1) begin
         errors++;
         $display("FAIL debug_entry: got %0d edges dbg=%b, required 2 edges dbg=1", n, debug_mode_o);
      end
      // Interrupts are ignored while in debug mode.
      @(posedge clk); #1;
      mstatus_i = 32'h8; mie_i = 32'h800; irq_external_i = 1'b1;
      #1;
      checks++;
      if (stall_flag_o !== 1'b0) begin
         errors++;
         $display("FAIL debug_irq_blocked: got stall=%b, required 0", stall_flag_o);
      end
      @(posedge clk); #1;
      irq_external_i = 1'b0; mstatus_i = 32'h0; mie_i = 32'h0;
      // ebreak inside debug mode re-enters with cause 1 and leaves dpc alone.
      inst_ebreak_i = 1'b1;
      push_csr(32'h7B0, 32'h4000_0043);
      push_redirect(32'h0000_0800);
      wait_redirect(n);
      checks++;
      if (n !== 2) begin
         errors++;
         $display("FAIL debug_ebreak_dm: got %0d edges, required 2", n);
      end
      @(posedge clk); #1;
      dpc_i = 32'h44; inst_dret_i = 1'b1;
      push_redirect(32'h0000_0044);
      wait_redirect(n);
      checks++;
      if (n !== 1 || debug_mode_o !== 1'b0) begin
         errors++;
         $display("FAIL dret: got %0d edges dbg=%b, required 1 edge dbg=0", n, debug_mode_o);
      end
      // ebreak with dcsr.ebreakm enters debug with cause 4.
      @(posedge clk); #1;
      dcsr_i = 32'h4000_8003; inst_addr_i = 32'h88; inst_ebreak_i = 1'b1;
      push_csr(32'h7B1, 32'h0000_0088);
      push_csr(32'h7B0, 32'h4000_8103);
      push_redirect(32'h0000_0800);
      wait_redirect(n);
      checks++;
      if (n !== 2 || debug_mode_o !== 1'b1) begin
         errors++;
         $display("FAIL debug_ebreakm: got %0d edges dbg=%b, required 2 edges dbg=1", n, debug_mode_o);
      end
      @(posedge clk); #1;
      dpc_i = 32'h8C; inst_dret_i = 1'b1;
      push_redirect(32'h0000_008C);
      wait_redirect(n);
      dcsr_i = 32'h0;
      checks++;
      if (n !== 1 || debug_mode_o !== 1'b0) begin
         errors++;
         $display("FAIL dret_2: got %0d edges dbg=%b, required 1 edge dbg=0", n, debug_mode_o);
      end
   endtask

   task automatic test_reset_mid_seq();
      @(posedge clk); #1;
      mtvec_i = 32'h8000_0000; mstatus_i = 32'h8; mie_i = 32'h800; inst_addr_i = 32'h1234;
      irq_external_i = 1'b1;
      push_csr(32'h342, 32'h8000_000B);
      @(posedge clk); #1;
      drop_requests();
      checks++;
      if (stall_flag_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_seq_stall: got %b, required 1", stall_flag_o);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({csr_we_o, csr_waddr_o, csr_wdata_o, stall_flag_o, int_addr_o, int_assert_o, debug_mode_o} !== '0) begin
         errors++;
         $display("FAIL mid_seq_reset: got we=%b waddr=%h wdata=%h stall=%b assert=%b, required all 0",
                  csr_we_o, csr_waddr_o, csr_wdata_o, stall_flag_o, int_assert_o);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL mid_seq_queue: got %0d pending, required 0", exp_q.size());
      end
      $display("reset mid-sequence done");
   endtask

   task automatic test_masked_irq();
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         mstatus_i = (k == 0) ? 32'h8 : 32'h0;
         mie_i     = (k == 0) ? 32'h0 : 32'hFFFF_FFFF;
         irq_external_i = 1'b1; irq_timer_i = 1'b1; irq_fast_i = 15'h7FFF;
         #1;
         checks++;
         if (stall_flag_o !== 1'b0) begin
            errors++;
            $display("FAIL masked_irq[%0d]: got stall=%b, required 0", k, stall_flag_o);
         end
         repeat (4) @(posedge clk);
         #1;
         drop_requests();
      end
      $display("masked irq done");
   endtask

   initial begin
      rst_n = 1'b0;
      inst_valid_i = 1'b1;
      inst_addr_i = '0; mtvec_i = '0; mepc_i = '0; mstatus_i = '0; mie_i = '0;
      dpc_i = '0; dcsr_i = '0; debug_halt_addr_i = '0;
      drop_requests();
      test_reset();
      test_direct_trap();
      test_vectored();
      test_exc_priority();
      test_mret();
      test_debug();
      test_reset_mid_seq();
      test_masked_irq();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
